// File: rtl/uart_loader_if.sv
// Bundle of the receiver, instruction-memory and CPU-side signals of the boot
// loader. The slave view belongs to the loader; the master view belongs to
// whatever drives it (receiver + CPU model, or a testbench).
interface uart_loader_if #(
    parameter int ADDR_W = 14
);
    // receiver side
    logic [31:0]       rx_data;
    logic              rx_valid;
    logic              rx_ready;
    // instruction-memory write port
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    // status and CPU word port
    logic              boot_done;
    logic              cpu_req;
    logic [31:0]       cpu_data;
    logic              cpu_ack;
    logic              ovf;

    modport slave (
        input  rx_data, rx_valid, cpu_req,
        output rx_ready, imem_we, imem_addr, imem_wdata,
        output boot_done, cpu_data, cpu_ack, ovf
    );

    modport master (
        output rx_data, rx_valid, cpu_req,
        input  rx_ready, imem_we, imem_addr, imem_wdata,
        input  boot_done, cpu_data, cpu_ack, ovf
    );
endinterface

// File: rtl/uart_loader.sv
// UART boot loader. The first received word is a length; that many words are
// written to instruction memory from address 0, then boot_done rises and all
// later words are queued in a small FIFO that the CPU drains one word per
// request. All outputs are registered.
module uart_loader #(
    parameter int ADDR_W     = 14,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    uart_loader_if.slave  bus
);

    localparam int               PTR_W   = $clog2(FIFO_DEPTH);
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    // largest image that fits the address space; longer lengths saturate here
    localparam logic [32:0]      MAX_LEN = 33'(1) << ADDR_W;

    typedef enum logic [1:0] {
        S_LEN,
        S_LOAD,
        S_RUN
    } state_e;

    state_e            state_q,      state_d;
    logic [32:0]       len_q,        len_d;
    logic [31:0]       word_cnt_q,   word_cnt_d;
    logic [PTR_W-1:0]  wr_ptr_q,     wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,     rd_ptr_d;
    logic [CNT_W-1:0]  occ_q,        occ_d;
    logic              rx_ready_q,   rx_ready_d;
    logic              imem_we_q,    imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q,  imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              boot_done_q,  boot_done_d;
    logic [31:0]       cpu_data_q,   cpu_data_d;
    logic              cpu_ack_q,    cpu_ack_d;
    logic              ovf_q,        ovf_d;

    logic              push;
    logic              pop;
    logic              fifo_full;
    logic [31:0]       fifo_mem [FIFO_DEPTH];

    // Next-state, datapath and FIFO control for the three boot phases
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        len_d        = len_q;
        word_cnt_d   = word_cnt_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        occ_d        = occ_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        boot_done_d  = boot_done_q;
        cpu_data_d   = cpu_data_q;
        cpu_ack_d    = 1'b0;
        ovf_d        = ovf_q;
        push         = 1'b0;
        pop          = 1'b0;
        // full is judged on occupancy before any same-cycle pop
        fifo_full    = (occ_q == DEPTH_C);

        case (state_q)
            S_LEN: begin
                if (bus.rx_valid) begin
                    len_d      = ({1'b0, bus.rx_data} > MAX_LEN) ? MAX_LEN : {1'b0, bus.rx_data};
                    word_cnt_d = '0;
                    if (bus.rx_data == 32'd0) begin
                        state_d     = S_RUN;
                        boot_done_d = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end

            S_LOAD: begin
                if (bus.rx_valid) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = word_cnt_q[ADDR_W-1:0];
                    imem_wdata_d = bus.rx_data;
                    // counter saturates rather than wrapping
                    if (word_cnt_q != '1) begin
                        word_cnt_d = word_cnt_q + 32'd1;
                    end
                    if ((33'(word_cnt_q) + 33'd1) == len_q) begin
                        state_d     = S_RUN;
                        boot_done_d = 1'b1;
                    end
                end
            end

            S_RUN: begin
                // one ack per request, never two in a row; data read from
                // the registered head, so a fresh push is not visible yet
                pop  = bus.cpu_req && (occ_q != '0) && !cpu_ack_q;
                push = bus.rx_valid && !fifo_full;
                if (bus.rx_valid && fifo_full) begin
                    ovf_d = 1'b1;
                end
                if (pop) begin
                    cpu_ack_d  = 1'b1;
                    cpu_data_d = fifo_mem[rd_ptr_q];
                    rd_ptr_d   = rd_ptr_q + PTR_W'(1);
                end
                if (push) begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                end
                if (push && !pop) begin
                    occ_d = occ_q + CNT_W'(1);
                end else if (pop && !push) begin
                    occ_d = occ_q - CNT_W'(1);
                end
            end

            default: state_d = S_LEN;
        endcase

        // ready reflects the state and occupancy that will hold next cycle
        rx_ready_d = (state_d != S_RUN) || (occ_d != DEPTH_C);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (rst) begin
            state_q      <= S_LEN;
            len_q        <= '0;
            word_cnt_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            rx_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            boot_done_q  <= 1'b0;
            cpu_data_q   <= '0;
            cpu_ack_q    <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_cnt_q   <= word_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            rx_ready_q   <= rx_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            boot_done_q  <= boot_done_d;
            cpu_data_q   <= cpu_data_d;
            cpu_ack_q    <= cpu_ack_d;
            ovf_q        <= ovf_d;
        end
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        // NOTE: the storage array is not reset; occupancy and pointers are,
        // so stale entries are never read.
        if (!rst && push) begin
            fifo_mem[wr_ptr_q] <= bus.rx_data;
        end
    end

    assign bus.rx_ready   = rx_ready_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign bus.boot_done  = boot_done_q;
    assign bus.cpu_data   = cpu_data_q;
    assign bus.cpu_ack    = cpu_ack_q;
    assign bus.ovf        = ovf_q;

endmodule

// File: doc/uart_loader.md
UART_LOADER -- requirements
Module: uart_loader

Interface
- REQ-001: Parameter ADDR_W, default 14, SHALL set the instruction-memory word-address width.
- REQ-002: Parameter FIFO_DEPTH, default 4 (power of 2, >=2), SHALL set the run-phase word FIFO depth.
- REQ-003: clk  in  1  SHALL be the single clock; all logic on posedge clk.
- REQ-004: rst  in  1  SHALL be the synchronous, active-high reset.
- REQ-005: rx_data  in  32  SHALL be the word from the UART receiver, valid only when rx_valid=1.
- REQ-006: rx_valid  in  1  SHALL be the receiver's one-cycle word-complete pulse.
- REQ-007: rx_ready  out  1  SHALL be the request that arms the receiver to deliver its next word.
- REQ-008: imem_we  out  1  SHALL be the instruction-memory write strobe, one cycle per word.
- REQ-009: imem_addr  out  ADDR_W  SHALL be the instruction-memory word address.
- REQ-010: imem_wdata  out  32  SHALL be the instruction-memory write data.
- REQ-011: boot_done  out  1  SHALL be high once loading completes, until reset.
- REQ-012: cpu_req  in  1  SHALL be the level request from the CPU input instruction.
- REQ-013: cpu_data  out  32  SHALL be the word returned to the CPU, valid when cpu_ack=1.
- REQ-014: cpu_ack  out  1  SHALL be the one-cycle pulse completing a CPU request.
- REQ-015: ovf  out  1  SHALL be a sticky flag: run-phase word dropped.

Function
- REQ-016: FSM states S_LEN, S_LOAD and S_RUN; all outputs registered.
- REQ-017: S_LEN: rx_ready=1; on rx_valid, latch len=rx_data; go to S_RUN with boot_done=1 next cycle if 0, else to S_LOAD.
- REQ-018: len greater than 2^ADDR_W SHALL saturate to 2^ADDR_W.
- REQ-019: S_LOAD: rx_ready=1; each rx_valid at cycle t SHALL yield imem_we=1, imem_wdata=rx_data, imem_addr=word index (from 0) at cycle t+1.
- REQ-020: After the rx_valid of word index len-1, state SHALL be S_RUN and boot_done=1 from cycle t+1; no further imem_we until reset.
- REQ-021: The 32-bit word counter SHALL never wrap; imem_addr is its low ADDR_W bits.
- REQ-022: S_RUN: rx_ready = FIFO not full; each rx_valid while not full SHALL push rx_data.
- REQ-023: rx_valid while FIFO full SHALL drop the word and set ovf=1 next cycle; ovf clears only on rst.
- REQ-024: Full/empty SHALL use an occupancy count of width clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
- REQ-025: Pop: if cpu_req=1, FIFO non-empty and cpu_ack=0 in cycle t, then cpu_ack=1 and cpu_data=head at t+1, head popped.
- REQ-026: cpu_ack SHALL never be high in two consecutive cycles.
- REQ-027: No bypass: a word pushed at t is ackable at t+2 at the earliest.
- REQ-028: Simultaneous push and pop SHALL leave occupancy unchanged; the full test uses pre-pop occupancy.
- REQ-029: rx_valid outside an accepting condition SHALL be ignored, except for the ovf case in REQ-023.
- REQ-030: cpu_req in S_LEN or S_LOAD SHALL remain pending with no ack.

Reset
- REQ-031: rst=1 SHALL force within one cycle: state S_LEN, counters/pointers 0, FIFO empty, len=0, rx_ready=0 (1 from the first cycle after rst falls), imem_we=0, imem_addr=0, imem_wdata=0, boot_done=0, cpu_data=0, cpu_ack=0, ovf=0.
- REQ-032: rst mid-load or mid-run SHALL abandon all progress; a pending imem_we SHALL not be issued.

Verification
- REQ-033: len=3, words A,B,C -> imem writes (0,A),(1,B),(2,C), each one cycle after its rx_valid; boot_done=1 after C.
- REQ-034: len=0 -> boot_done=1 the cycle after the length word, no imem_we; next word goes to the FIFO.
- REQ-035: FIFO_DEPTH=4 in S_RUN, cpu_req=0, 5 words -> rx_ready=0 after 4th; 5th rx_valid forced -> dropped, ovf=1; later acks return words 1-4 in order.
- REQ-036: cpu_req held high, FIFO holds X,Y -> acks at t+1 (X), t+3 (Y), none at t+2.
- REQ-037: Push and pop in the same cycle at occupancy 2 -> occupancy stays 2; data order preserved.
- REQ-038: rst asserted after 2 of len=5 words -> all outputs at reset values; a new length word restarts at imem_addr 0.
